// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Fixed 33-cycle latency: shift-add multiply, restoring divide.
package riscv_pkg;
  localparam int XLEN = 32;
endpackage

module muldiv_unit
  import riscv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  typedef enum logic {IDLE, CALC} state_e;

  state_e state_q, state_d;

  logic [4:0]        cnt_q;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              valid_q;
  logic [XLEN-1:0]   res_q, res_d;

  logic              idle, accept, done;
  logic              sgn_a, sgn_b, a_neg, b_neg, neg_d;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_t, div_r;
  logic              div_ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i && !flush_i) state_d = CALC;
      CALC: if (flush_i || cnt_q == 5'd31) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idle    = (state_q == IDLE);
    busy_o  = (state_q == CALC);
    stall_o = (start_i && idle) || busy_o;
    accept  = idle && start_i && !flush_i;
    done    = busy_o && !flush_i && cnt_q == 5'd31;
  end

  // Operand signedness follows funct3: op[2] selects divide, op[0]/op[1] unsigned.
  always_comb begin
    sgn_a = op_i[2] ? !op_i[0] : (op_i[1:0] != 2'b11);
    sgn_b = op_i[2] ? !op_i[0] : !op_i[1];
    a_neg = sgn_a && rs1_i[XLEN-1];
    b_neg = sgn_b && rs2_i[XLEN-1];
    a_mag = a_neg ? -rs1_i : rs1_i;
    b_mag = b_neg ? -rs2_i : rs2_i;
    unique case (1'b1)
      !op_i[2]:            neg_d = a_neg ^ b_neg;
      op_i[2:1] == 2'b10:  neg_d = (a_neg ^ b_neg) && (|rs2_i);
      op_i[2:1] == 2'b11:  neg_d = a_neg;
      default:             neg_d = 1'b0;
    endcase
  end

  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
            + (acc_q[0] ? {1'b0, b_q} : '0);
    div_t   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge  = (div_t >= {1'b0, b_q});
    div_r   = div_ge ? div_t - {1'b0, b_q} : div_t;
    if (op_q[2])
      acc_d = {div_r[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
    else
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
  end

  always_comb begin
    prod = neg_q ? -acc_d : acc_d;
    quo  = acc_d[XLEN-1:0];
    rem  = acc_d[2*XLEN-1:XLEN];
    unique case (1'b1)
      op_q == 3'b000:                 res_d = prod[XLEN-1:0];
      !op_q[2] && (|op_q[1:0]):       res_d = prod[2*XLEN-1:XLEN];
      op_q[2:1] == 2'b10:             res_d = neg_q ? -quo : quo;
      op_q[2:1] == 2'b11:             res_d = neg_q ? -rem : rem;
      default:                        res_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      valid_q <= done;
      if (done) res_q <= res_d;
      if (accept) begin
        cnt_q <= '0;
        op_q  <= op_i;
        rd_q  <= rd_addr_i;
        neg_q <= neg_d;
        b_q   <= op_i[2] ? b_mag : a_mag;
        acc_q <= {{XLEN{1'b0}}, op_i[2] ? a_mag : b_mag};
      end else if (busy_o && !flush_i) begin
        cnt_q <= cnt_q + 5'd1;
        acc_q <= acc_d;
      end
    end
  end

  assign valid_o   = valid_q;
  assign result_o  = res_q;
  assign rd_addr_o = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors,
// latency, stall, flush, reset and back-to-back behaviour.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  logic        flush;
  logic        busy, stall, valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .op_i     (op),
    .rs1_i    (rs1),
    .rs2_i    (rs2),
    .rd_addr_i(rd),
    .flush_i  (flush),
    .busy_o   (busy),
    .stall_o  (stall),
    .valid_o  (valid),
    .result_o (result),
    .rd_addr_o(rd_out)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got result %h rd %0d expected none",
                 result, rd_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("rd_addr", {27'd0, rd_out}, {27'd0, e.rd});
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r);
    start = 1'b1;
    op    = o;
    rs1   = a;
    rs2   = b;
    rd    = r;
  endtask

  task automatic run_op(input string nm, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input logic [31:0] exp,
                        input bit noise);
    int n;
    int stalls;
    bit got;
    exp_t e;
    @(negedge clk);
    issue(o, a, b, r);
    #1;
    chk({nm, "_stall_start"}, {31'd0, stall}, 32'd1);
    e.res = exp;
    e.rd  = r;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    stalls = 1;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if (valid) got = 1'b1;
      else if (stall) stalls++;
      if (!got && noise && (n == 5 || n == 6 || n == 20)) begin
        issue(3'b100, 32'd99, 32'd9, 5'd30);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({nm, "_latency"}, n, 33);
    chk({nm, "_stall_cycles"}, stalls, 33);
    chk({nm, "_stall_drop"}, {31'd0, stall}, 32'd0);
    chk({nm, "_busy_drop"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk({nm, "_valid_1cyc"}, {31'd0, valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] prev;
    exp_t e;
    rst = 1'b1;
    start = 1'b0;
    op = '0;
    rs1 = '0;
    rs2 = '0;
    rd = '0;
    flush = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", {27'd0, rd_out}, 32'd0);
    chk("rst_stall_lo", {31'd0, stall}, 32'd0);
    start = 1'b1;
    #1;
    chk("rst_stall_hi", {31'd0, stall}, 32'd1);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 0);
    run_op("mulh", 3'b001, 32'h80000000, 32'h80000000, 5'd6, 32'h40000000, 0);
    run_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE, 0);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFF, 0);
    run_op("div_neg", 3'b100, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFD, 0);
    run_op("rem_neg", 3'b110, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFF, 0);
    run_op("divu", 3'b101, 32'd100, 32'd7, 5'd11, 32'd14, 0);
    run_op("remu", 3'b111, 32'd100, 32'd7, 5'd12, 32'd2, 0);
    run_op("div_by0", 3'b100, 32'd5, 32'd0, 5'd13, 32'hFFFFFFFF, 0);
    run_op("remu_by0", 3'b111, 32'd5, 32'd0, 5'd14, 32'd5, 0);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 0);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0, 0);
    run_op("mul_noise", 3'b000, 32'd3, 32'd4, 5'd17, 32'd12, 1);

    // flush a DIV at its tenth cycle; nothing pushed, so any valid is flagged
    prev = result;
    @(negedge clk);
    issue(3'b101, 32'd100, 32'd7, 5'd18);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_valid", {31'd0, valid}, 32'd0);
    chk("flush_result", result, prev);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid) n++;
    end
    chk("flush_no_valid", n, 0);

    // asynchronous reset in the middle of a MUL
    @(negedge clk);
    issue(3'b000, 32'd5, 32'd6, 5'd21);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_valid", {31'd0, valid}, 32'd0);
    chk("mrst_result", result, 32'd0);
    chk("mrst_rd", {27'd0, rd_out}, 32'd0);
    chk("mrst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid) n++;
    end
    chk("mrst_no_valid", n, 0);

    // back-to-back: second start in the first valid cycle
    @(negedge clk);
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
    e.res = 32'hFFFFFFFE;
    e.rd  = 5'd3;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 40);
    chk("b2b_first_lat", n, 33);
    issue(3'b111, 32'd100, 32'd7, 5'd4);
    e.res = 32'd2;
    e.rd  = 5'd4;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 40);
    chk("b2b_spacing", n, 33);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
